// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: receives a byte-stream program frame, writes it word by word
// into the instruction store, and holds the core stalled until the XOR checksum verifies.
module inst_mem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx;
  logic [7:0]  remaining;
  logic [31:0] word_q;
  logic [7:0]  csum_q;
  logic        accept;
  logic        restart;
  logic        word_end;

  assign accept = rx_valid && rx_ready;

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    word_end = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          restart = 1'b1;
        end
      end
      S_HDR: begin
        if (accept) state_d = S_DATA;
      end
      S_DATA: begin
        if (accept && byte_idx == 2'd3) begin
          word_end = 1'b1;
          if (remaining == 8'd0) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Status outputs are decoded from the next state so they change in step with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      rx_ready <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
      busy     <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
      cpu_hold <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM)
                  || (state_d == S_ERR);
      done     <= (state_d == S_DONE);
      error    <= (state_d == S_ERR);
      mem_we   <= word_end;
    end
  end

  // mem_wdata is a separate copy so the next word can start assembling during the write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx  <= '0;
      remaining <= '0;
      word_q    <= '0;
      csum_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (restart) begin
      byte_idx <= '0;
      word_q   <= '0;
      csum_q   <= '0;
      mem_addr <= '0;
    end else begin
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (state_q == S_HDR && accept) remaining <= rx_data;
      if (state_q == S_DATA && accept) begin
        word_q[{byte_idx, 3'b000} +: 8] <= rx_data;
        csum_q   <= csum_q ^ rx_data;
        byte_idx <= byte_idx + 2'd1;
        if (word_end) begin
          mem_wdata <= {rx_data, word_q[23:0]};
          if (remaining != 8'd0) remaining <= remaining - 8'd1;
        end
      end
    end
  end

endmodule
